// File: rtl/tv_recorder_if.sv
// Readout stream of the test-vector recorder.
//   valid : data holds a captured vector
//   ready : consumer accepts data this cycle
//   data  : captured vector
//   last  : data is the final captured vector
// master drives the stream (recorder), slave consumes it.
interface tv_recorder_if #(
  parameter int unsigned VEC_W = 4
);
  logic             valid;
  logic             ready;
  logic [VEC_W-1:0] data;
  logic             last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/tv_recorder.sv
// Test-vector recorder. Captures one VEC_W-bit vector per qualified clock into a
// DEPTH-entry buffer, then streams the vectors out in capture order over a
// valid/ready port.
// Ports:
//   clk          clock, all state changes on posedge
//   reset        synchronous, active-high reset
//   arm_i        start (or restart) a capture
//   stop_i       end the capture early
//   cap_valid_i  capture cap_vec_i this cycle
//   cap_vec_i    vector to capture
//   dump_i       start readout of the captured vectors
//   busy_o       recording or dumping
//   done_o       capture finished, buffer holds count_o vectors
//   full_o       count_o == DEPTH
//   count_o      number of vectors captured
//   dout_io      readout stream (valid/ready/data/last)
module tv_recorder #(
  parameter int unsigned VEC_W = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm_i,
  input  logic             stop_i,
  input  logic             cap_valid_i,
  input  logic [VEC_W-1:0] cap_vec_i,
  input  logic             dump_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             full_o,
  output logic [AW:0]      count_o,
  tv_recorder_if.master    dout_io
);

  localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRec, StDone, StDump} state_e;

  state_e           state_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [AW:0]      count_q;
  logic             dout_valid_q;
  logic [VEC_W-1:0] dout_q;
  logic             dout_last_q;
  logic             xfer;
  logic             wr_en;

  // Buffer is deliberately not reset; only the pointers and count are.
  logic [VEC_W-1:0] mem_q [DEPTH];

  assign wr_en      = (state_q == StRec) && cap_valid_i && !reset;
  assign xfer       = dout_valid_q && dout_io.ready;
  assign rd_ptr_nxt = rd_ptr_q + AW'(1);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= cap_vec_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      dout_last_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (arm_i) begin
            state_q  <= StRec;
            wr_ptr_q <= '0;
            count_q  <= '0;
          end
        end
        StRec: begin
          if (cap_valid_i) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            count_q  <= count_q + 1'b1;
          end
          // Leave on stop, or when this write fills the last entry; no wrap-around.
          if (stop_i || (cap_valid_i && (count_q == DepthCnt - 1'b1))) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (arm_i) begin
            state_q  <= StRec;
            wr_ptr_q <= '0;
            count_q  <= '0;
          end else if (dump_i) begin
            if (count_q != '0) begin
              // Present mem[0] straight away so valid rises the next cycle.
              state_q      <= StDump;
              rd_ptr_q     <= '0;
              dout_valid_q <= 1'b1;
              dout_q       <= mem_q[AW'(0)];
              dout_last_q  <= (count_q == (AW+1)'(1));
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StDump: begin
          if (xfer) begin
            if (dout_last_q) begin
              state_q      <= StIdle;
              dout_valid_q <= 1'b0;
              dout_last_q  <= 1'b0;
            end else begin
              rd_ptr_q    <= rd_ptr_nxt;
              dout_q      <= mem_q[rd_ptr_nxt];
              dout_last_q <= ({1'b0, rd_ptr_nxt} == count_q - 1'b1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o  = (state_q == StRec) || (state_q == StDump);
  assign done_o  = (state_q == StDone);
  assign full_o  = (count_q == DepthCnt);
  assign count_o = count_q;

  assign dout_io.valid = dout_valid_q;
  assign dout_io.data  = dout_q;
  assign dout_io.last  = dout_last_q;

endmodule
